// File: rtl/sram_test_pkg.sv
// Shared definitions for the SRAM test sequencer: FSM states, pattern modes and LFSR constants.
package sram_test_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    RD_ADDR,
    RD_CHECK,
    DONE
  } state_t;

  localparam logic [1:0] PAT_FIXED   = 2'd0;
  localparam logic [1:0] PAT_ADDR    = 2'd1;
  localparam logic [1:0] PAT_LFSR    = 2'd2;
  localparam logic [1:0] PAT_CHECKER = 2'd3;

  localparam logic [7:0] LFSR_MASK     = 8'hB8;
  localparam logic [7:0] LFSR_ZERO_SUB = 8'h01;

  localparam int ERR_W = 16;

  // Right-shifting Galois step for x^8+x^6+x^5+x^4+1.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return s[0] ? ({1'b0, s[7:1]} ^ LFSR_MASK) : {1'b0, s[7:1]};
  endfunction

endpackage

// File: rtl/sram_pat_gen.sv
// Pattern generator: LFSR register plus the combinational pattern mux with optional inversion.
module sram_pat_gen
  import sram_test_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        advance,
  input  logic [7:0]  load_seed,
  input  logic [1:0]  mode,
  input  logic [7:0]  seed,
  input  logic [15:0] addr_lsb,
  input  logic        invert,
  output logic [7:0]  pattern
);

  logic [7:0] lfsr;
  logic [7:0] raw;

  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr <= LFSR_ZERO_SUB;
    end else if (load) begin
      lfsr <= (load_seed == 8'h00) ? LFSR_ZERO_SUB : load_seed;
    end else if (advance) begin
      lfsr <= lfsr_step(lfsr);
    end
  end

  always_comb begin
    raw = 8'h00;
    case (mode)
      PAT_FIXED: raw = seed;
      PAT_ADDR:  raw = addr_lsb[7:0] ^ addr_lsb[15:8];
      PAT_LFSR:  raw = lfsr;
      default:   raw = addr_lsb[0] ? 8'hAA : 8'h55;
    endcase
  end

  assign pattern = invert ? ~raw : raw;

endmodule

// File: rtl/sram_test_seq.sv
// SRAM test sequencer: writes a pattern over [addr_lo, addr_hi], reads it back and logs mismatches.
// Define SRAM_TEST_INVERT_PASS_EN to add a second write+read pass with the inverted pattern.
module sram_test_seq
  import sram_test_pkg::*;
#(
  parameter int ADDR_W    = 21,
  parameter int WE_CYCLES = 2,
  parameter int RD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr_lo,
  input  logic [ADDR_W-1:0] addr_hi,
  input  logic [1:0]        pat_mode,
  input  logic [7:0]        seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [7:0]        first_err_exp,
  output logic [7:0]        first_err_got,
  output logic              rw,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        data_f2s,
  input  logic [7:0]        data_s2f_r
);

  localparam logic [7:0] WE_LOAD = 8'(WE_CYCLES - 1);
  localparam logic [7:0] RD_LOAD = 8'(RD_CYCLES - 1);

  state_t            state;
  logic [ADDR_W-1:0] lo_q;
  logic [ADDR_W-1:0] hi_q;
  logic [1:0]        mode_q;
  logic [7:0]        seed_q;
  logic [7:0]        cnt;
  logic [7:0]        pattern;
  logic              start_ok;
  logic              at_hi;
  logic              mismatch;
  logic              restart;
  logic              invert;
  logic              lfsr_load;
  logic              lfsr_adv;

  assign start_ok = start && ((state == IDLE) || (state == DONE));
  assign at_hi    = (addr == hi_q);
  assign mismatch = (state == RD_CHECK) && (data_s2f_r != pattern);

`ifdef SRAM_TEST_INVERT_PASS_EN
  logic pass2;
  assign invert  = pass2;
  assign restart = (state == RD_CHECK) && at_hi && !pass2;
`else
  assign invert  = 1'b0;
  assign restart = 1'b0;
`endif

  assign lfsr_load = start_ok || ((state == WR_HOLD) && at_hi) || restart;
  assign lfsr_adv  = ((state == WR_HOLD) || (state == RD_CHECK)) && !at_hi;

  // Write data is a pure function of registered state, so it only moves when addr moves.
  assign data_f2s = pattern;

  sram_pat_gen u_pat_gen (
    .clk       (clk),
    .reset     (reset),
    .load      (lfsr_load),
    .advance   (lfsr_adv),
    .load_seed (start_ok ? seed : seed_q),
    .mode      (mode_q),
    .seed      (seed_q),
    .addr_lsb  (addr[15:0]),
    .invert    (invert),
    .pattern   (pattern)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      rw             <= 1'b1;
      addr           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_exp  <= 8'h00;
      first_err_got  <= 8'h00;
      lo_q           <= '0;
      hi_q           <= '0;
      mode_q         <= 2'd0;
      seed_q         <= 8'h00;
      cnt            <= 8'h00;
`ifdef SRAM_TEST_INVERT_PASS_EN
      pass2          <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            lo_q           <= addr_lo;
            hi_q           <= addr_hi;
            mode_q         <= pat_mode;
            seed_q         <= seed;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_exp  <= 8'h00;
            first_err_got  <= 8'h00;
            addr           <= addr_lo;
`ifdef SRAM_TEST_INVERT_PASS_EN
            pass2          <= 1'b0;
`endif
            if (addr_lo > addr_hi) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state <= WR_SETUP;
              busy  <= 1'b1;
              done  <= 1'b0;
              pass  <= 1'b0;
            end
          end
        end
        WR_SETUP: begin
          rw    <= 1'b0;
          cnt   <= WE_LOAD;
          state <= WR_PULSE;
        end
        WR_PULSE: begin
          if (cnt == 8'h00) begin
            rw    <= 1'b1;
            state <= WR_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WR_HOLD: begin
          if (at_hi) begin
            addr  <= lo_q;
            cnt   <= RD_LOAD;
            state <= RD_ADDR;
          end else begin
            addr  <= addr + 1'b1;
            state <= WR_SETUP;
          end
        end
        RD_ADDR: begin
          if (cnt == 8'h00) begin
            state <= RD_CHECK;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RD_CHECK: begin
          if (mismatch) begin
            if (err_count != '1) begin
              err_count <= err_count + 1'b1;
            end
            if (err_count == '0) begin
              first_err_addr <= addr;
              first_err_exp  <= pattern;
              first_err_got  <= data_s2f_r;
            end
          end
          if (!at_hi) begin
            addr  <= addr + 1'b1;
            cnt   <= RD_LOAD;
            state <= RD_ADDR;
          end else if (restart) begin
            addr  <= lo_q;
            state <= WR_SETUP;
`ifdef SRAM_TEST_INVERT_PASS_EN
            pass2 <= 1'b1;
`endif
          end else begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0) && !mismatch;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
